// File: rtl/npc_ras.sv
// Fetch-stage next-PC generator: holds the fetch PC and predicts `jr $ra`
// targets from a circular return-address stack filled by jal/jalr.
module npc_ras #(
  parameter int unsigned       RAS_DEPTH = 8,
  parameter logic [31:0]       RESET_PC  = 32'h0000_3000,
  parameter logic [31:0]       EXC_VEC   = 32'h0000_4180
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           stall,
  input  logic [2:0]                     npc_op,
  input  logic [25:0]                    imm,
  input  logic [31:0]                    ra,
  input  logic [31:0]                    epc,
  input  logic                           call,
  input  logic                           ras_flush,
  output logic [31:0]                    pc,
  output logic [31:0]                    pc4,
  output logic [31:0]                    npc,
  output logic                           ras_mispredict,
  output logic [$clog2(RAS_DEPTH):0]     ras_count
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [2:0] {
    OP_SEQ    = 3'b000,
    OP_BRANCH = 3'b001,
    OP_JUMP   = 3'b010,
    OP_JR     = 3'b011,
    OP_ERET   = 3'b100,
    OP_EXC    = 3'b101,
    OP_RET    = 3'b110,
    OP_RSVD   = 3'b111
  } npc_op_e;

  logic [31:0]   r_pc;
  logic [31:0]   r_stack [RAS_DEPTH];
  logic [PW-1:0] r_tp;
  logic [CW-1:0] r_count;

  npc_op_e       w_op;
  logic [31:0]   w_pc4;
  logic [31:0]   w_pc8;
  logic [31:0]   w_br_off;
  logic [31:0]   w_top;
  logic          w_nonempty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_we;
  logic [PW-1:0] w_waddr;
  logic [PW-1:0] w_tp_next;
  logic [CW-1:0] w_count_next;
  logic [31:0]   w_npc;

  assign w_op       = npc_op_e'(npc_op);
  assign w_pc4      = r_pc + 32'd4;
  assign w_pc8      = r_pc + 32'd8;
  assign w_br_off   = {{14{imm[15]}}, imm[15:0], 2'b00};
  assign w_top      = r_stack[r_tp];
  assign w_nonempty = (r_count != '0);
  assign w_full     = (r_count == CW'(RAS_DEPTH));
  assign w_pop      = (w_op == OP_RET) && w_nonempty;
  assign w_push     = call;

  always_comb begin
    w_npc = w_pc4;
    unique case (w_op)
      OP_SEQ:    w_npc = w_pc4;
      OP_BRANCH: w_npc = w_pc4 + w_br_off;
      OP_JUMP:   w_npc = {r_pc[31:28], imm, 2'b00};
      OP_JR:     w_npc = ra;
      OP_ERET:   w_npc = epc;
      OP_EXC:    w_npc = EXC_VEC;
      OP_RET:    w_npc = w_nonempty ? w_top : ra;
      OP_RSVD:   w_npc = w_pc4;
      default:   w_npc = w_pc4;
    endcase
  end

  // Pop-then-push collapses to an in-place overwrite of the current top.
  always_comb begin
    w_tp_next    = r_tp;
    w_count_next = r_count;
    w_we         = 1'b0;
    w_waddr      = r_tp + PW'(1);
    if (w_pop && w_push) begin
      w_we    = 1'b1;
      w_waddr = r_tp;
    end else if (w_pop) begin
      w_tp_next    = r_tp - PW'(1);
      w_count_next = r_count - CW'(1);
    end else if (w_push) begin
      w_we         = 1'b1;
      w_tp_next    = r_tp + PW'(1);
      w_count_next = w_full ? r_count : r_count + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc    <= RESET_PC;
      r_tp    <= '0;
      r_count <= '0;
    end else if (!stall) begin
      r_pc <= w_npc;
      if (ras_flush) begin
        r_tp    <= '0;
        r_count <= '0;
      end else begin
        r_tp    <= w_tp_next;
        r_count <= w_count_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !stall && !ras_flush && w_we) begin
      r_stack[w_waddr] <= w_pc8;
    end
  end

  assign pc             = r_pc;
  assign pc4            = w_pc4;
  assign npc            = w_npc;
  assign ras_mispredict = w_pop && (w_top != ra);
  assign ras_count      = r_count;

endmodule

// File: tb/tb_npc_ras.sv
// Directed bench for npc_ras: reset, jumps, call/return, overflow/underflow,
// stall/flush, exception/ERET and simultaneous pop+push.
module tb_npc_ras;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [2:0]  npc_op;
  logic [25:0] imm;
  logic [31:0] ra;
  logic [31:0] epc;
  logic        call;
  logic        ras_flush;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic [31:0] npc;
  logic        ras_mispredict;
  logic [3:0]  ras_count;

  int n_cmp;
  int n_bad;

  npc_ras #(
    .RAS_DEPTH(8),
    .RESET_PC (32'h0000_3000),
    .EXC_VEC  (32'h0000_4180)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .npc_op        (npc_op),
    .imm           (imm),
    .ra            (ra),
    .epc           (epc),
    .call          (call),
    .ras_flush     (ras_flush),
    .pc            (pc),
    .pc4           (pc4),
    .npc           (npc),
    .ras_mispredict(ras_mispredict),
    .ras_count     (ras_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [25:0] im, input logic [31:0] r,
                       input logic c);
    npc_op = op;
    imm    = im;
    ra     = r;
    call   = c;
    #1;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    reset = 1'b1; stall = 1'b0; npc_op = 3'b000; imm = '0; ra = '0;
    epc = '0; call = 1'b0; ras_flush = 1'b0;

    // Reset held two cycles
    tick(); tick();
    chk("rst_pc", pc, 32'h3000);
    chk("rst_pc4", pc4, 32'h3004);
    chk("rst_cnt", 32'(ras_count), 32'd0);
    chk("rst_mis", 32'(ras_mispredict), 32'd0);

    reset = 1'b0;
    drive(3'b000, '0, '0, 1'b0);
    tick(); chk("seq1", pc, 32'h3004);
    tick(); chk("seq2", pc, 32'h3008);
    tick(); tick(); chk("seq4", pc, 32'h3010);

    // Branch backwards and absolute jump, combinational only
    drive(3'b001, 26'h000FFFE, '0, 1'b0); chk("br_back", npc, 32'h300C);
    drive(3'b010, 26'h0000C40, '0, 1'b0); chk("jmp", npc, 32'h3100);
    drive(3'b111, '0, '0, 1'b0);          chk("rsvd_seq", npc, 32'h3014);
    drive(3'b011, '0, 32'h1234_5678, 1'b0);
    chk("jr_npc", npc, 32'h1234_5678);
    chk("jr_mis", 32'(ras_mispredict), 32'd0);

    // Call / return, correct prediction
    drive(3'b010, 26'h0000C08, '0, 1'b0); tick(); chk("to3020", pc, 32'h3020);
    drive(3'b010, 26'h0000C40, '0, 1'b1); tick();
    chk("call_pc", pc, 32'h3100);
    chk("call_cnt", 32'(ras_count), 32'd1);
    drive(3'b110, '0, 32'h3028, 1'b0);
    chk("ret_npc", npc, 32'h3028);
    chk("ret_mis0", 32'(ras_mispredict), 32'd0);
    tick();
    chk("ret_cnt", 32'(ras_count), 32'd0);
    chk("ret_pc", pc, 32'h3028);

    // Call / return, wrong prediction
    drive(3'b010, 26'h0000C08, '0, 1'b0); tick();
    drive(3'b010, 26'h0000C40, '0, 1'b1); tick();
    drive(3'b110, '0, 32'h4000, 1'b0);
    chk("misp_npc", npc, 32'h3028);
    chk("misp_flag", 32'(ras_mispredict), 32'd1);
    tick();
    chk("misp_cnt", 32'(ras_count), 32'd0);
    chk("misp_pc", pc, 32'h3028);

    // Overflow: nine sequential calls push 0x3030..0x3050
    for (int k = 0; k < 9; k++) begin
      drive(3'b000, '0, '0, 1'b1); tick();
    end
    chk("ovf_cnt", 32'(ras_count), 32'd8);
    chk("ovf_pc", pc, 32'h304C);
    for (int k = 8; k >= 1; k--) begin
      drive(3'b110, '0, 32'h3030 + 32'(4 * k), 1'b0);
      chk($sformatf("pop%0d_npc", k), npc, 32'h3030 + 32'(4 * k));
      chk($sformatf("pop%0d_mis", k), 32'(ras_mispredict), 32'd0);
      tick();
    end
    chk("drain_cnt", 32'(ras_count), 32'd0);
    drive(3'b110, '0, 32'h3500, 1'b0);
    chk("udf_npc", npc, 32'h3500);
    chk("udf_mis", 32'(ras_mispredict), 32'd0);
    tick();
    chk("udf_cnt", 32'(ras_count), 32'd0);
    chk("udf_pc", pc, 32'h3500);

    // Stall holds PC and RAS, outputs stay live
    drive(3'b000, '0, '0, 1'b1); tick();
    chk("pre_stall_cnt", 32'(ras_count), 32'd1);
    stall = 1'b1;
    drive(3'b110, '0, 32'h3508, 1'b1);
    chk("stall_npc", npc, 32'h3508);
    tick();
    chk("stall_pc", pc, 32'h3504);
    chk("stall_cnt", 32'(ras_count), 32'd1);
    stall = 1'b0;

    // Flush beats a same-cycle push
    ras_flush = 1'b1;
    drive(3'b000, '0, '0, 1'b1); tick();
    chk("flush_cnt", 32'(ras_count), 32'd0);
    chk("flush_pc", pc, 32'h3508);
    ras_flush = 1'b0;

    // Three pushes: 0x3510, 0x3514, 0x3518
    for (int k = 0; k < 3; k++) begin
      drive(3'b000, '0, '0, 1'b1); tick();
    end
    chk("p3_cnt", 32'(ras_count), 32'd3);

    // Exception and ERET leave the RAS alone
    drive(3'b101, '0, '0, 1'b0); chk("exc_npc", npc, 32'h4180);
    tick();
    chk("exc_pc", pc, 32'h4180);
    chk("exc_cnt", 32'(ras_count), 32'd3);
    epc = 32'h3ABC;
    drive(3'b100, '0, '0, 1'b0); chk("eret_npc", npc, 32'h3ABC);
    tick();
    chk("eret_cnt", 32'(ras_count), 32'd3);

    // Simultaneous pop and push replaces the top with PC+8 = 0x3AC4
    drive(3'b110, '0, 32'h3518, 1'b1);
    chk("pp_npc", npc, 32'h3518);
    chk("pp_mis", 32'(ras_mispredict), 32'd0);
    tick();
    chk("pp_cnt", 32'(ras_count), 32'd3);
    drive(3'b110, '0, 32'h3AC4, 1'b0);
    chk("pp_top", npc, 32'h3AC4);
    tick();
    chk("pp_cnt2", 32'(ras_count), 32'd2);
    drive(3'b110, '0, 32'h3514, 1'b0);
    chk("pp_next", npc, 32'h3514);

    // Reset mid-operation abandons the pop
    reset = 1'b1; tick();
    chk("rst2_pc", pc, 32'h3000);
    chk("rst2_cnt", 32'(ras_count), 32'd0);
    chk("rst2_mis", 32'(ras_mispredict), 32'd0);
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/npc_ras.md
# npc_ras

Next-PC generator with an integrated PC register and a parametrised return-address stack (RAS), for the fetch stage of the pipelined MIPS core. It computes the next fetch address from sequential, branch, jump, register-jump, ERET and exception requests. It holds the architectural fetch PC and predicts `jr $ra` targets from a circular stack filled by `jal`/`jalr`. It flags a misprediction when the predicted target differs from the resolved register value.

## Interface
- `RAS_DEPTH`, 8: stack entries; power of two, 2..64.
- `RESET_PC`, 32'h0000_3000: PC value after reset.
- `EXC_VEC`, 32'h0000_4180: exception handler entry.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `stall` in 1: hold PC and RAS this cycle.
- `npc_op` in 3: 000 seq, 001 branch, 010 j/jal, 011 jr (non-return), 100 eret, 101 exception, 110 return (`jr $ra`), 111 reserved (treated as seq).
- `imm` in 26: instr[25:0]; branch uses [15:0].
- `ra` in 32: resolved register value for 011/110.
- `epc` in 32: EPC from CP0.
- `call` in 1: push PC+8 onto RAS this cycle (jal/jalr).
- `ras_flush` in 1: empty the RAS.
- `pc` out 32: current fetch PC (register).
- `pc4` out 32: `pc` + 4.
- `npc` out 32: selected next PC (combinational).
- `ras_mispredict` out 1: return prediction wrong (combinational).
- `ras_count` out $clog2(RAS_DEPTH)+1: valid entries.

## Operation
- `npc` select by `npc_op`:
  - 000: `pc`+4.
  - 001: `pc`+4+sext(imm[15:0])<<2.
  - 010: {`pc`[31:28], imm, 2'b00}.
  - 011: `ra`.
  - 100: `epc`.
  - 101: `EXC_VEC`.
  - 110: RAS top if `ras_count`≠0, else `ra`.
  - 111: `pc`+4.
- All arithmetic is modulo 2^32; carries are discarded and wrap silently.
- `ras_mispredict` = (`npc_op`==110) && `ras_count`≠0 && top≠`ra`. The block does not redirect by itself. The pipeline recovers by presenting 011 with the same `ra` on a later cycle.
- RAS storage: `RAS_DEPTH` × 32 array, top pointer `tp`, counter `ras_count`.
  - Push writes PC+8 (delay slot return address) at `tp`+1 mod DEPTH and advances `tp`.
  - `ras_count` saturates at DEPTH. A push when full overwrites the oldest entry, because the pointer wraps.
  - Pop (`npc_op`==110 with count≠0) decrements `tp` mod DEPTH and decrements the count. A pop when empty is a no-op and falls back to `ra`.
- Simultaneous pop and `call` (jalr $ra,$ra): the pop takes effect first, then the push. Net effect: the top entry is replaced by PC+8, `tp` is unchanged and the count is unchanged (an empty stack becomes count 1).
- Priority per cycle: `reset` > `stall` > `ras_flush` > push/pop.
  - `ras_flush` sets count=0 and `tp`=0. Any push or pop in the same cycle is discarded.
  - `npc` is still computed normally during a flush.
- `stall`=1: `pc`, array, `tp` and count all hold. `npc` and `ras_mispredict` still reflect the current inputs.
- `npc_op`==101 or 100 does not touch the RAS, unless `call` or `ras_flush` is asserted.

## Timing
- Reset (sync, on the `clk` edge with `reset`=1): `pc`=`RESET_PC`, `pc4`=`RESET_PC`+4, `ras_count`=0, `tp`=0. Array contents are don't-care.
- During reset, `npc` and `ras_mispredict` are combinational from the held state (count 0, so `ras_mispredict`=0).
- Reset asserted mid-operation abandons any push or pop in that cycle.
- `npc`, `pc4` and `ras_mispredict` have zero latency (combinational) from `pc`, the inputs and the RAS top.
- `pc` <= `npc` on each rising edge with `stall`=0 and `reset`=0. Latency is one cycle.
- RAS updates on the same edge. The new top is visible to the next cycle's 110.
- No combinational path from `npc` back into the RAS write data. The write data is PC+8 of the current `pc`.

## Test plan
- Reset: hold `reset` 2 cycles → `pc`=0x3000, `pc4`=0x3004, `ras_count`=0. Release with op 000 → `pc` goes 0x3004, 0x3008.
- Branch/jump: `pc`=0x3010, op 001, imm[15:0]=0xFFFE → `npc`=0x300C. Op 010, imm=0x0000C40 → `npc`=0x3100.
- Call/return: at `pc`=0x3020, `call`=1 with op 010 → count 1. Then op 110 with `ra`=0x3028 → `npc`=0x3028, mispredict 0, count 0 next cycle. Repeat with `ra`=0x4000 → `npc`=0x3028, mispredict 1.
- Overflow/underflow: with DEPTH=8, push 9 distinct return addresses A1..A9 → count 8. Pops return A9..A2, then a pop on the empty stack → `npc`=`ra`, count stays 0, mispredict 0.
- Stall and flush: `stall`=1 with `call`=1 and op 110 → `pc` and count unchanged. `ras_flush`=1 with `call`=1 → count 0 next cycle.
- Exception/ERET: op 101 → `npc`=0x4180. Op 100 with `epc`=0x3ABC → `npc`=0x3ABC. Count unchanged in both. Simultaneous pop and push on count 3 → count stays 3 and the top equals PC+8.
